x_mult_acc_pipe: RTL and testbench

//   Parametrised pipelined multiplier-accumulator. Next-generation successor to the

---
 rtl/x_mult_acc_pipe.sv | 93 +++++++++
 tb/tb_x_mult_acc_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/x_mult_acc_pipe.sv
// x_mult_acc_pipe: pipelined signed/unsigned MAC with valid tracking and sticky overflow.
// Define X_MULT_ACC_SAT_EN to saturate P on overflow instead of wrapping.
module x_mult_acc_pipe #(
  parameter int A_WIDTH     = 18,
  parameter int B_WIDTH     = 18,
  parameter int ACC_WIDTH   = 48,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 i_c,
  input  logic                 i_r,
  input  logic                 i_ce,
  input  logic                 i_clr,
  input  logic                 i_in_valid,
  input  logic                 i_signed_mode,
  input  logic                 i_acc_en,
  input  logic [A_WIDTH-1:0]   i_a,
  input  logic [B_WIDTH-1:0]   i_b,
  output logic [ACC_WIDTH-1:0] o_p,
  output logic                 o_out_valid,
  output logic                 o_ovf
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int L  = PIPE_STAGES - 1;
  localparam int M  = ACC_WIDTH - 1;
  logic [A_WIDTH-1:0]   r_a;
  logic [B_WIDTH-1:0]   r_b;
  logic                 r_sm, r_ae, r_v0;
  logic [ACC_WIDTH-1:0] r_pp [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] r_ps, r_pa, r_pv;
  logic [PW-1:0]        w_ax, w_bx, w_prod;
  logic [ACC_WIDTH-1:0] w_prod_ext, w_p_next;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_ovf;
  // Extending both operands to the full product width makes one unsigned multiply
  // yield the correct low PW bits for either mode.
  assign w_ax       = r_sm ? PW'($signed(r_a)) : PW'(r_a);
  assign w_bx       = r_sm ? PW'($signed(r_b)) : PW'(r_b);
  assign w_prod     = w_ax * w_bx;
  assign w_prod_ext = r_sm ? ACC_WIDTH'($signed(w_prod)) : ACC_WIDTH'(w_prod);
  assign w_sum      = {1'b0, o_p} + {1'b0, r_pp[L]};
  assign w_ovf      = r_pa[L] & (r_ps[L] ? (o_p[M] == r_pp[L][M]) && (w_sum[M] != o_p[M])
                                         : w_sum[ACC_WIDTH]);
`ifdef X_MULT_ACC_SAT_EN
  logic [ACC_WIDTH-1:0] w_sat;
  assign w_sat    = r_ps[L] ? (o_p[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}}) : '1;
  assign w_p_next = !r_pa[L] ? r_pp[L] : w_ovf ? w_sat : w_sum[M:0];
`else
  assign w_p_next = r_pa[L] ? w_sum[M:0] : r_pp[L];
`endif
  always_ff @(posedge i_c or posedge i_r) begin
    if (i_r) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sm        <= 1'b0;
      r_ae        <= 1'b0;
      r_v0        <= 1'b0;
      r_ps        <= '0;
      r_pa        <= '0;
      r_pv        <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) r_pp[i] <= '0;
      o_p         <= '0;
      o_out_valid <= 1'b0;
      o_ovf       <= 1'b0;
    end else if (i_clr) begin
      r_v0        <= 1'b0;
      r_pv        <= '0;
      o_p         <= '0;
      o_out_valid <= 1'b0;
      o_ovf       <= 1'b0;
    end else if (i_ce) begin
      r_a         <= i_a;
      r_b         <= i_b;
      r_sm        <= i_signed_mode;
      r_ae        <= i_acc_en;
      r_v0        <= i_in_valid;
      r_pp[0]     <= w_prod_ext;
      r_ps[0]     <= r_sm;
      r_pa[0]     <= r_ae;
      r_pv[0]     <= r_v0;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        r_pp[i] <= r_pp[i-1];
        r_ps[i] <= r_ps[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pv[i] <= r_pv[i-1];
      end
      o_out_valid <= r_pv[L];
      if (r_pv[L]) begin
        o_p   <= w_p_next;
        o_ovf <= o_ovf | w_ovf;
      end
    end
  end
endmodule

// File: tb/tb_x_mult_acc_pipe.sv
// tb_x_mult_acc_pipe: vector table plus scoreboard for x_mult_acc_pipe (48- and 36-bit builds).
module tb_x_mult_acc_pipe;
  logic clk = 1'b0;
  logic rst, ce, clr, iv, sm, ae;
  logic [17:0] a, b;
  logic [47:0] p;
  logic ov, ovf;
  logic [35:0] p2;
  logic ov2, ovf2;
  int total = 0;
  int bad = 0;
  typedef struct {logic [47:0] p; logic ovf;} exp_t;
  typedef struct {logic s; logic e; logic [17:0] a; logic [17:0] b; logic [47:0] p; logic ovf;} vec_t;
  exp_t q[$];
  exp_t e_mon;
  vec_t tv[10];
  logic ce_seen = 1'b0;
  logic [47:0] t4_p [10] = '{0, 0, 0, 6, 6, 6, 20, 62, 1, 1};
  logic        t4_v [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
  logic [17:0] t4_a [4]  = '{2, 4, 6, 1};
  logic [17:0] t4_b [4]  = '{3, 5, 7, 1};
  logic        t4_e [4]  = '{0, 0, 1, 0};

  always #5 clk = ~clk;

  x_mult_acc_pipe dut (
    .i_c(clk), .i_r(rst), .i_ce(ce), .i_clr(clr), .i_in_valid(iv), .i_signed_mode(sm),
    .i_acc_en(ae), .i_a(a), .i_b(b), .o_p(p), .o_out_valid(ov), .o_ovf(ovf));

  x_mult_acc_pipe #(.ACC_WIDTH(36)) dut36 (
    .i_c(clk), .i_r(rst), .i_ce(ce), .i_clr(clr), .i_in_valid(iv), .i_signed_mode(sm),
    .i_acc_en(ae), .i_a(a), .i_b(b), .o_p(p2), .o_out_valid(ov2), .o_ovf(ovf2));

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic e, input logic [17:0] x, input logic [17:0] y);
    iv = 1'b1; sm = s; ae = e; a = x; b = y;
    tick();
    iv = 1'b0;
  endtask

  // Only edges that actually advanced the pipeline can produce a new result.
  always @(posedge clk) ce_seen <= ce & ~clr & ~rst;

  always @(negedge clk) begin
    if (ce_seen && ov) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual=out_valid required=no_output p=%h", p);
      end else begin
        e_mon = q.pop_front();
        chk("sb_p", p, e_mon.p);
        chk("sb_ovf", {47'd0, ovf}, {47'd0, e_mon.ovf});
      end
    end
  end

  initial begin
    tv[0] = '{1'b1, 1'b0, 18'h3FFFD, 18'd5,     48'hFFFF_FFFF_FFF1, 1'b0};
    tv[1] = '{1'b1, 1'b1, 18'd7,     18'h3FFFE, 48'hFFFF_FFFF_FFE3, 1'b0};
    tv[2] = '{1'b0, 1'b0, 18'h3FFFF, 18'h3FFFF, 48'h000F_FFF8_0001, 1'b0};
    tv[3] = '{1'b0, 1'b1, 18'h3FFFF, 18'h3FFFF, 48'h001F_FFF0_0002, 1'b0};
    tv[4] = '{1'b1, 1'b0, 18'h20000, 18'h20000, 48'h0004_0000_0000, 1'b0};
    tv[5] = '{1'b0, 1'b0, 18'h20000, 18'd2,     48'h0000_0004_0000, 1'b0};
    tv[6] = '{1'b1, 1'b1, 18'h20000, 18'd2,     48'h0000_0000_0000, 1'b0};
    tv[7] = '{1'b1, 1'b1, 18'd100,   18'h3FFFF, 48'hFFFF_FFFF_FF9C, 1'b0};
`ifdef X_MULT_ACC_SAT_EN
    tv[8] = '{1'b0, 1'b1, 18'd1,     18'd100,   48'hFFFF_FFFF_FFFF, 1'b1};
`else
    tv[8] = '{1'b0, 1'b1, 18'd1,     18'd100,   48'h0000_0000_0000, 1'b1};
`endif
    tv[9] = '{1'b0, 1'b0, 18'd5,     18'd5,     48'd25,             1'b1};
    rst = 1'b1; ce = 1'b1; clr = 1'b0; iv = 1'b0; sm = 1'b0; ae = 1'b0; a = '0; b = '0;
    tick();
    tick();
    chk("rst_p", p, 48'd0);
    chk("rst_ov", {47'd0, ov}, 48'd0);
    chk("rst_ovf", {47'd0, ovf}, 48'd0);
    rst = 1'b0;
    tick();
    // single signed load, latency of three edges
    q.push_back('{48'hFFFF_FFFF_FFF1, 1'b0});
    send(1'b1, 1'b0, 18'h3FFFD, 18'd5);
    chk("lat_e0", {47'd0, ov}, 48'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("lat_e%0d", i), {47'd0, ov}, {47'd0, i == 3});
    end
    chk("lat_p", p, 48'hFFFF_FFFF_FFF1);
    // back-to-back vector table through the scoreboard
    for (int i = 0; i < 10; i++) begin
      q.push_back('{tv[i].p, tv[i].ovf});
      send(tv[i].s, tv[i].e, tv[i].a, tv[i].b);
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("tbl_drain", 48'(q.size()), 48'd0);
    // async reset while a result is showing and another sample is in flight
    send(1'b0, 1'b0, 18'd3, 18'd3);
    send(1'b0, 1'b0, 18'd4, 18'd4);
    tick();
    tick();
    chk("ar_pre_ov", {47'd0, ov}, 48'd1);
    chk("ar_pre_p", p, 48'd9);
    chk("ar_pre_ovf", {47'd0, ovf}, 48'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_p", p, 48'd0);
    chk("ar_ov", {47'd0, ov}, 48'd0);
    chk("ar_ovf", {47'd0, ovf}, 48'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ar_flushed_p", p, 48'd0);
    // four-sample stream with CE low for two edges
    for (int i = 0; i < 10; i++) begin
      ce = !(i == 4 || i == 5);
      iv = i < 4;
      if (i < 4) begin
        sm = 1'b0; ae = t4_e[i]; a = t4_a[i]; b = t4_b[i];
        q.push_back('{t4_p[i == 0 ? 3 : i + 5], 1'b0});
      end
      tick();
      chk($sformatf("stall_ov_e%0d", i), {47'd0, ov}, {47'd0, t4_v[i]});
      chk($sformatf("stall_p_e%0d", i), p, t4_p[i]);
    end
    ce = 1'b1;
    iv = 1'b0;
    // CLR with two samples in flight while CE is low
    send(1'b0, 1'b0, 18'd2, 18'd2);
    send(1'b0, 1'b0, 18'd3, 18'd3);
    chk("clr_pre_p", p, 48'd1);
    ce = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_p", p, 48'd0);
    tick();
    ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("clr_no_ov", {47'd0, ov}, 48'd0);
    end
    chk("clr_post_p", p, 48'd0);
    // 36-bit accumulator unsigned overflow, then CLR
    q.push_back('{48'h000F_FFF8_0001, 1'b0});
    send(1'b0, 1'b0, 18'h3FFFF, 18'h3FFFF);
    q.push_back('{48'h001F_FFF0_0002, 1'b0});
    send(1'b0, 1'b1, 18'h3FFFF, 18'h3FFFF);
    tick();
    tick();
    chk("w36_load_p", {12'd0, p2}, 48'h000F_FFF8_0001);
    chk("w36_load_ovf", {47'd0, ovf2}, 48'd0);
    tick();
`ifdef X_MULT_ACC_SAT_EN
    chk("w36_acc_p", {12'd0, p2}, 48'h000F_FFFF_FFFF);
`else
    chk("w36_acc_p", {12'd0, p2}, 48'h000F_FFF0_0002);
`endif
    chk("w36_acc_ovf", {47'd0, ovf2}, 48'd1);
    chk("w48_acc_ovf", {47'd0, ovf}, 48'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("w36_clr_p", {12'd0, p2}, 48'd0);
    chk("w36_clr_ovf", {47'd0, ovf2}, 48'd0);
    chk("w48_clr_p", p, 48'd0);
    tick();
    chk("sb_empty", 48'(q.size()), 48'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
